gru_mac_sequencer: RTL

Control FSM that sequences one GRU layer evaluation over a shared single-MAC datapath, one multiply-accumulate per cycle. It runs gate Z, then R, then H, one neuron at a time. For each neuron it runs bias load, input-weight MAC, recurrent-weight MAC and accumulator writeback. It then runs a per-neuron state-update pass. It sits between the layer-level scheduler (start/done) and the GRU datapath (bias/weight memories, accumulator, sigmoid/tanh LUTs, state register).

---
 rtl/gru_mac_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/gru_mac_sequencer.sv
// gru_mac_sequencer: sequences one GRU layer (gates Z,R,H then state update) over one MAC.
// Optional GRU_SEQ_PERF_EN adds perf_cycles / stall_cycles counters.
module gru_mac_sequencer #(
  parameter int NB_INPUTS  = 24,
  parameter int NB_NEURONS = 24,
  parameter int ADDR_W     = 16,
  parameter int IDX_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mac_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        gate,
  output logic [IDX_W-1:0]  neuron_idx,
  output logic              acc_clear,
  output logic [ADDR_W-1:0] bias_addr,
  output logic              in_mac_en,
  output logic [IDX_W-1:0]  in_idx,
  output logic [ADDR_W-1:0] in_w_addr,
  output logic              rec_mac_en,
  output logic              rec_mul_r,
  output logic [IDX_W-1:0]  state_idx,
  output logic [ADDR_W-1:0] rec_w_addr,
  output logic              acc_wr,
  output logic              upd_en
`ifdef GRU_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       stall_cycles
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BIAS = 3'd1;
  localparam logic [2:0] S_IN   = 3'd2;
  localparam logic [2:0] S_REC  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_UPD  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [IDX_W-1:0]  LAST_IN = IDX_W'(NB_INPUTS - 1);
  localparam logic [IDX_W-1:0]  LAST_N  = IDX_W'(NB_NEURONS - 1);
  localparam logic [ADDR_W-1:0] N_A     = ADDR_W'(NB_NEURONS);
  localparam logic [ADDR_W-1:0] ROW_A   = ADDR_W'(3 * NB_NEURONS);

  logic [2:0]        state, nxt_state;
  logic [1:0]        g, nxt_g;
  logic [IDX_W-1:0]  j, nxt_j;
  logic [IDX_W-1:0]  k, nxt_k;
  logic [ADDR_W-1:0] nxt_col;
  logic [ADDR_W-1:0] nxt_row;

  always_comb begin
    nxt_state = state;
    nxt_g     = g;
    nxt_j     = j;
    nxt_k     = k;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_BIAS;
          nxt_g     = 2'd0;
          nxt_j     = '0;
          nxt_k     = '0;
        end
      end
      S_BIAS: begin
        if (mac_ready) begin
          nxt_state = S_IN;
          nxt_k     = '0;
        end
      end
      S_IN: begin
        if (mac_ready) begin
          if (k == LAST_IN) begin
            nxt_state = S_REC;
            nxt_k     = '0;
          end else begin
            nxt_k = k + 1'b1;
          end
        end
      end
      S_REC: begin
        if (mac_ready) begin
          if (k == LAST_N) nxt_state = S_WR;
          else             nxt_k = k + 1'b1;
        end
      end
      S_WR: begin
        if (mac_ready) begin
          if (j != LAST_N) begin
            nxt_j     = j + 1'b1;
            nxt_state = S_BIAS;
          end else if (g != 2'd2) begin
            nxt_g     = g + 2'd1;
            nxt_j     = '0;
            nxt_state = S_BIAS;
          end else begin
            nxt_j     = '0;
            nxt_state = S_UPD;
          end
        end
      end
      S_UPD: begin
        if (mac_ready) begin
          if (j == LAST_N) nxt_state = S_DONE;
          else             nxt_j = j + 1'b1;
        end
      end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Addresses are built from next-cycle counters so they land with their strobe.
  assign nxt_col = ADDR_W'(nxt_g) * N_A + ADDR_W'(nxt_j);
  assign nxt_row = ADDR_W'(nxt_k) * ROW_A;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      g          <= 2'd0;
      j          <= '0;
      k          <= '0;
      bias_addr  <= '0;
      in_idx     <= '0;
      in_w_addr  <= '0;
      state_idx  <= '0;
      rec_w_addr <= '0;
    end else begin
      state <= nxt_state;
      g     <= nxt_g;
      j     <= nxt_j;
      k     <= nxt_k;
      if (nxt_state == S_BIAS) bias_addr <= nxt_col;
      if (nxt_state == S_IN) begin
        in_idx    <= nxt_k;
        in_w_addr <= nxt_row + nxt_col;
      end
      if (nxt_state == S_REC) begin
        state_idx  <= nxt_k;
        rec_w_addr <= nxt_row + nxt_col;
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign gate       = g;
  assign neuron_idx = j;
  assign acc_clear  = (state == S_BIAS) & mac_ready;
  assign in_mac_en  = (state == S_IN) & mac_ready;
  assign rec_mac_en = (state == S_REC) & mac_ready;
  assign rec_mul_r  = rec_mac_en & (g == 2'd2);
  assign acc_wr     = (state == S_WR) & mac_ready;
  assign upd_en     = (state == S_UPD) & mac_ready;

`ifdef GRU_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles  <= '0;
      stall_cycles <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        perf_cycles  <= '0;
        stall_cycles <= '0;
      end
    end else begin
      perf_cycles <= perf_cycles + 32'd1;
      if (!mac_ready && state != S_DONE) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
